rec_reader: RTL and testbench

Parametrised, cached, read-only record fetcher between the ray-tracing pipeline and SDRAM over an Avalon-MM master port. It generalises the triangle reader to any record size, bus width and cache depth. It adds a valid/ready request and response handshake, a flush input and hit/miss counters. Each request returns one record (for example, one triangle) by index. Hits come from an internal direct-mapped cache; misses are fetched beat-by-beat from memory.

---
 rtl/rec_reader.sv | 157 +++++++++++++++
 tb/tb_rec_reader.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rec_reader.sv
// Cached read-only record fetcher: one record per request, served from a direct-mapped cache or
// fetched beat-by-beat over an Avalon-MM read master. One request is in flight at a time.
module rec_reader #(
  parameter int BUSW   = 16,
  parameter int NBEATS = 18,
  parameter int IDXW   = 32,
  parameter int NLINES = 256
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             baseaddr,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [IDXW-1:0]         req_index,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [NBEATS*BUSW-1:0]  resp_data,
  output logic                    resp_hit,
  input  logic                    flush,
  output logic [31:0]             hit_count,
  output logic [31:0]             miss_count,
  output logic                    avm_m0_read,
  output logic                    avm_m0_write,
  output logic [31:0]             avm_m0_address,
  output logic [BUSW-1:0]         avm_m0_writedata,
  output logic [BUSW/8-1:0]       avm_m0_byteenable,
  input  logic [BUSW-1:0]         avm_m0_readdata,
  input  logic                    avm_m0_readdatavalid,
  input  logic                    avm_m0_waitrequest
);

  localparam int RECW = NBEATS * BUSW;
  localparam int LB   = $clog2(NLINES);
  localparam int TW   = IDXW - LB;
  localparam int CW   = $clog2(NBEATS + 1);
  localparam logic [31:0]   REC_BYTES  = 32'(NBEATS * (BUSW / 8));
  localparam logic [31:0]   BEAT_BYTES = 32'(BUSW / 8);
  localparam logic [CW-1:0] LAST       = CW'(NBEATS - 1);
  localparam logic [CW-1:0] FULL       = CW'(NBEATS);

  typedef enum logic [2:0] {IDLE, LOOKUP, ISSUE, DRAIN, RESP} state_t;
  state_t state, state_nxt;

  logic [IDXW-1:0]   idx;
  logic [NLINES-1:0] valid;
  logic [TW-1:0]     tag_mem  [NLINES];
  logic [RECW-1:0]   data_mem [NLINES];
  logic [TW-1:0]     rd_tag;
  logic [RECW-1:0]   rd_data;
  logic [RECW-1:0]   fill;
  logic [RECW-1:0]   fill_nxt;
  logic [CW-1:0]     icnt;
  logic [CW-1:0]     rcnt;
  logic              fill_kill;

  logic [LB-1:0] line;
  logic [TW-1:0] tag;
  logic          accept;
  logic          hit;
  logic          beat_ok;
  logic          beat_in;
  logic          fill_done;

  assign line      = idx[LB-1:0];
  assign tag       = idx[IDXW-1:LB];
  assign accept    = req_valid && req_ready;
  assign hit       = valid[line] && (rd_tag == tag);
  assign beat_ok   = avm_m0_read && !avm_m0_waitrequest;
  assign beat_in   = avm_m0_readdatavalid && ((state == ISSUE) || (state == DRAIN)) && (rcnt != FULL);
  // The final beat is merged combinationally so the response leaves one cycle after it arrives.
  assign fill_done = (state == DRAIN) && ((rcnt == FULL) || (beat_in && (rcnt == LAST)));

  assign req_ready         = (state == IDLE);
  assign resp_valid        = (state == RESP);
  assign avm_m0_read       = (state == ISSUE);
  assign avm_m0_write      = 1'b0;
  assign avm_m0_writedata  = '0;
  assign avm_m0_byteenable = '1;
  assign avm_m0_address    = baseaddr + 32'(idx) * REC_BYTES + 32'(icnt) * BEAT_BYTES;

  always_comb begin
    fill_nxt = fill;
    for (int k = 0; k < NBEATS; k++) begin
      if (beat_in && (rcnt == CW'(k))) fill_nxt[k*BUSW +: BUSW] = avm_m0_readdata;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = LOOKUP;
      LOOKUP:  state_nxt = hit ? RESP : ISSUE;
      ISSUE:   if (beat_ok && (icnt == LAST)) state_nxt = DRAIN;
      DRAIN:   if (fill_done) state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Tag/data storage: registered read started at request acceptance, checked in LOOKUP.
  always_ff @(posedge clk) begin
    if (accept) begin
      rd_tag  <= tag_mem[req_index[LB-1:0]];
      rd_data <= data_mem[req_index[LB-1:0]];
    end
    if (fill_done && !reset) begin
      tag_mem[line]  <= tag;
      data_mem[line] <= fill_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx        <= '0;
      valid      <= '0;
      icnt       <= '0;
      rcnt       <= '0;
      fill       <= '0;
      fill_kill  <= 1'b0;
      resp_data  <= '0;
      resp_hit   <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (accept) idx <= req_index;
      fill <= fill_nxt;
      if (beat_in) rcnt <= rcnt + 1'b1;
      if (beat_ok) icnt <= icnt + 1'b1;
      // A flush seen while the fill is outstanding must keep that line invalid.
      if (flush && ((state == ISSUE) || (state == DRAIN))) fill_kill <= 1'b1;
      if (state == LOOKUP) begin
        if (hit) begin
          resp_data <= rd_data;
          resp_hit  <= 1'b1;
          if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
        end else begin
          icnt      <= '0;
          rcnt      <= '0;
          fill_kill <= 1'b0;
          if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
        end
      end
      if (fill_done) begin
        resp_data <= fill_nxt;
        resp_hit  <= 1'b0;
      end
      if (flush) valid <= '0;
      else if (fill_done && !fill_kill) valid[line] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rec_reader.sv
// Directed bench for rec_reader: Avalon memory model with fixed read latency and a
// programmable waitrequest stall on one address; expected records computed from the address map.
module tb_rec_reader;
  localparam int BUSW   = 16;
  localparam int NBEATS = 18;
  localparam int RECW   = NBEATS * BUSW;
  localparam int LAT    = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [31:0]       baseaddr = 32'h1000;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [31:0]       req_index = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b1;
  logic [RECW-1:0]   resp_data;
  logic              resp_hit;
  logic              flush = 1'b0;
  logic [31:0]       hit_count;
  logic [31:0]       miss_count;
  logic              avm_m0_read;
  logic              avm_m0_write;
  logic [31:0]       avm_m0_address;
  logic [BUSW-1:0]   avm_m0_writedata;
  logic [BUSW/8-1:0] avm_m0_byteenable;
  logic [BUSW-1:0]   avm_m0_readdata = '0;
  logic              avm_m0_readdatavalid = 1'b0;
  logic              avm_m0_waitrequest = 1'b0;

  rec_reader dut (
    .clk(clk), .reset(reset), .baseaddr(baseaddr),
    .req_valid(req_valid), .req_ready(req_ready), .req_index(req_index),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_hit(resp_hit),
    .flush(flush), .hit_count(hit_count), .miss_count(miss_count),
    .avm_m0_read(avm_m0_read), .avm_m0_write(avm_m0_write), .avm_m0_address(avm_m0_address),
    .avm_m0_writedata(avm_m0_writedata), .avm_m0_byteenable(avm_m0_byteenable),
    .avm_m0_readdata(avm_m0_readdata), .avm_m0_readdatavalid(avm_m0_readdatavalid),
    .avm_m0_waitrequest(avm_m0_waitrequest)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [31:0] q_addr[$];
  int          q_due[$];
  logic [31:0] acc_q[$];
  logic [31:0] wait_addr = 32'hFFFF_FFFF;
  int          wait_left = 0;
  int          hold_cnt = 0;
  int          rd_cycles = 0;
  int          first_rd = -1;

  function automatic logic [15:0] mem_val(input logic [31:0] a);
    return (a[15:0] * 16'd7) ^ 16'h3C5A;
  endfunction

  function automatic logic [RECW-1:0] exp_rec(input logic [31:0] idx);
    logic [RECW-1:0] r;
    logic [31:0] a;
    r = '0;
    for (int k = 0; k < NBEATS; k++) begin
      a = 32'h1000 + idx * 32'd36 + 32'(k * 2);
      r[k*BUSW +: BUSW] = mem_val(a);
    end
    return r;
  endfunction

  // Avalon slave model, evaluated mid-cycle so everything it drives is stable at the next edge.
  always @(negedge clk) begin
    if (reset) begin
      q_addr.delete();
      q_due.delete();
      avm_m0_readdatavalid = 1'b0;
      avm_m0_waitrequest = 1'b0;
    end else begin
      avm_m0_waitrequest = 1'b0;
      if (avm_m0_read && avm_m0_address == wait_addr) begin
        hold_cnt++;
        if (wait_left > 0) begin
          avm_m0_waitrequest = 1'b1;
          wait_left--;
        end
      end
      if (avm_m0_read) begin
        rd_cycles++;
        if (first_rd < 0) first_rd = cyc;
      end
      if (avm_m0_read && !avm_m0_waitrequest) begin
        acc_q.push_back(avm_m0_address);
        q_addr.push_back(avm_m0_address);
        q_due.push_back(cyc + LAT);
      end
      avm_m0_readdatavalid = 1'b0;
      if (q_due.size() > 0 && q_due[0] == cyc) begin
        avm_m0_readdatavalid = 1'b1;
        avm_m0_readdata = mem_val(q_addr[0]);
        void'(q_addr.pop_front());
        void'(q_due.pop_front());
      end
    end
  end

  task automatic do_req(input logic [31:0] i, output logic [RECW-1:0] d, output logic h,
                        output int lat, output int hc);
    int n;
    n = 0;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    req_valid = 1'b1;
    req_index = i;
    @(negedge clk);
    hc = cyc;
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 500) begin @(negedge clk); n++; end
    checks++;
    if (resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL resp_timeout idx=%0d got resp_valid=%b want 1", i, resp_valid);
    end
    d = resp_data;
    h = resp_hit;
    lat = cyc - hc;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_hit !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs got ready=%b valid=%b hit=%b want 1 0 0", req_ready, resp_valid, resp_hit);
    end
    checks++;
    if (resp_data !== '0 || hit_count !== 32'd0 || miss_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_data got data=%h hits=%0d misses=%0d want 0 0 0", resp_data, hit_count, miss_count);
    end
    checks++;
    if (avm_m0_read !== 1'b0 || avm_m0_write !== 1'b0 || avm_m0_writedata !== '0 || avm_m0_byteenable !== 2'b11) begin
      errors++;
      $display("FAIL reset_avm got rd=%b wr=%b wd=%h be=%b want 0 0 0 11",
               avm_m0_read, avm_m0_write, avm_m0_writedata, avm_m0_byteenable);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_burst(input string name, input logic [31:0] first);
    int bad;
    bad = 0;
    for (int i = 0; i < acc_q.size(); i++) if (acc_q[i] !== first + 32'(2 * i)) bad++;
    checks++;
    if (bad != 0 || acc_q.size() != NBEATS) begin
      errors++;
      $display("FAIL %s_burst got beats=%0d bad_addr=%0d first=%h want beats=18 bad_addr=0 first=%h",
               name, acc_q.size(), bad, (acc_q.size() > 0) ? acc_q[0] : 32'h0, first);
    end
  endtask

  task automatic test_cold_miss();
    logic [RECW-1:0] d; logic h; int lat, hc;
    acc_q.delete();
    first_rd = -1;
    do_req(32'd2, d, h, lat, hc);
    check_burst("cold", 32'h1048);
    checks++;
    if (acc_q.size() == NBEATS && acc_q[NBEATS-1] !== 32'h106A) begin
      errors++;
      $display("FAIL cold_last_addr got %h want 106a", acc_q[NBEATS-1]);
    end
    checks++;
    if (d !== exp_rec(32'd2) || h !== 1'b0) begin
      errors++;
      $display("FAIL cold_data got hit=%b data=%h want hit=0 data=%h", h, d, exp_rec(32'd2));
    end
    // LOOKUP occupies the cycle after the handshake, so the first read follows one cycle later.
    checks++;
    if (first_rd - hc != 1 || miss_count !== 32'd1) begin
      errors++;
      $display("FAIL cold_timing got read_delay=%0d misses=%0d want 1 1", first_rd - hc, miss_count);
    end
  endtask

  task automatic test_hit();
    logic [RECW-1:0] d; logic h; int lat, hc;
    rd_cycles = 0;
    do_req(32'd2, d, h, lat, hc);
    checks++;
    if (lat != 1 || h !== 1'b1 || rd_cycles != 0) begin
      errors++;
      $display("FAIL hit_resp got delay=%0d hit=%b reads=%0d want 1 1 0", lat, h, rd_cycles);
    end
    checks++;
    if (d !== exp_rec(32'd2) || hit_count !== 32'd1) begin
      errors++;
      $display("FAIL hit_data got hits=%0d data=%h want 1 %h", hit_count, d, exp_rec(32'd2));
    end
  endtask

  task automatic test_conflict();
    logic [RECW-1:0] d1, d2; logic h1, h2; int lat, hc;
    do_req(32'd258, d1, h1, lat, hc);
    do_req(32'd2, d2, h2, lat, hc);
    checks++;
    if (h1 !== 1'b0 || h2 !== 1'b0 || miss_count !== 32'd3) begin
      errors++;
      $display("FAIL conflict_miss got hit258=%b hit2=%b misses=%0d want 0 0 3", h1, h2, miss_count);
    end
    checks++;
    if (d1 !== exp_rec(32'd258) || d2 !== exp_rec(32'd2)) begin
      errors++;
      $display("FAIL conflict_data got %h / %h want %h / %h", d1, d2, exp_rec(32'd258), exp_rec(32'd2));
    end
  endtask

  task automatic test_waitrequest();
    logic [RECW-1:0] d; logic h; int lat, hc;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    acc_q.delete();
    hold_cnt = 0;
    wait_addr = 32'h1056;
    wait_left = 5;
    do_req(32'd2, d, h, lat, hc);
    wait_addr = 32'hFFFF_FFFF;
    checks++;
    if (hold_cnt != 6) begin
      errors++;
      $display("FAIL wait_hold got cycles_at_1056=%0d want 6", hold_cnt);
    end
    check_burst("wait", 32'h1048);
    checks++;
    if (d !== exp_rec(32'd2) || h !== 1'b0 || miss_count !== 32'd4 || hit_count !== 32'd1) begin
      errors++;
      $display("FAIL wait_data got hit=%b misses=%0d hits=%0d data=%h want 0 4 1 %h",
               h, miss_count, hit_count, d, exp_rec(32'd2));
    end
  endtask

  task automatic test_flush_drain();
    logic [RECW-1:0] d; logic h; int lat, hc;
    acc_q.delete();
    fork
      do_req(32'd5, d, h, lat, hc);
      begin
        int n;
        n = 0;
        while (acc_q.size() < NBEATS && n < 400) begin @(posedge clk); n++; end
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
      end
    join
    checks++;
    if (d !== exp_rec(32'd5) || h !== 1'b0) begin
      errors++;
      $display("FAIL flush_drain_data got hit=%b data=%h want 0 %h", h, d, exp_rec(32'd5));
    end
    do_req(32'd5, d, h, lat, hc);
    checks++;
    if (h !== 1'b0 || d !== exp_rec(32'd5) || miss_count !== 32'd6) begin
      errors++;
      $display("FAIL flush_drain_refetch got hit=%b misses=%0d want 0 6", h, miss_count);
    end
  endtask

  task automatic test_backpressure();
    logic [RECW-1:0] snap;
    int n, bad;
    resp_ready = 1'b0;
    req_valid = 1'b1;
    req_index = 32'd5;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 100) begin @(negedge clk); n++; end
    snap = resp_data;
    checks++;
    if (resp_valid !== 1'b1 || resp_hit !== 1'b1 || snap !== exp_rec(32'd5)) begin
      errors++;
      $display("FAIL bp_first got valid=%b hit=%b data=%h want 1 1 %h", resp_valid, resp_hit, snap, exp_rec(32'd5));
    end
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (resp_data !== snap || req_ready !== 1'b0 || resp_valid !== 1'b1 || resp_hit !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold got unstable_cycles=%0d want 0", bad);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || hit_count !== 32'd2) begin
      errors++;
      $display("FAIL bp_release got valid=%b ready=%b hits=%0d want 0 1 2", resp_valid, req_ready, hit_count);
    end
  endtask

  task automatic test_reset_mid_issue();
    logic [RECW-1:0] d; logic h; int lat, hc, n;
    req_valid = 1'b1;
    req_index = 32'd7;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!avm_m0_read && n < 50) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    checks++;
    if (avm_m0_read !== 1'b1) begin
      errors++;
      $display("FAIL rst_setup got read=%b want 1", avm_m0_read);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (avm_m0_read !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_hit !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_hs got read=%b valid=%b ready=%b hit=%b want 0 0 1 0",
               avm_m0_read, resp_valid, req_ready, resp_hit);
    end
    checks++;
    if (resp_data !== '0 || hit_count !== 32'd0 || miss_count !== 32'd0) begin
      errors++;
      $display("FAIL rst_mid_data got data=%h hits=%0d misses=%0d want 0 0 0", resp_data, hit_count, miss_count);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_req(32'd7, d, h, lat, hc);
    checks++;
    if (h !== 1'b0 || d !== exp_rec(32'd7) || miss_count !== 32'd1) begin
      errors++;
      $display("FAIL rst_refetch got hit=%b misses=%0d data=%h want 0 1 %h", h, miss_count, d, exp_rec(32'd7));
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_waitrequest();
    test_flush_drain();
    test_backpressure();
    test_reset_mid_issue();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
